// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Stall / flush / forwarding generator for a 5-stage RV32i pipeline.
//   - Combinational forwarding (M has priority over W) and load-use detect.
//   - Post-reset flush: Flush_D/Flush_E held for RESET_FLUSH_CYCLES edges.
//   - Data-memory wait FSM (IDLE/WAIT) with a sticky timeout flag.
//   - Saturating performance counters for stall cycles and flush events.
//
// Ports
//   CLK, RST                       clock (rising edge), async active-high reset
//   RS1_D, RS2_D                   Decode source registers
//   RS1_E, RS2_E, RD_E             Execute source/destination registers
//   Result_Src_Sel_E               Execute result select (2'b01 = load)
//   PC_Src_E                       taken branch/jump resolved in Execute
//   RD_M, RD_W, REG_W_En_M/W       Memory/Writeback destination and write enables
//   MEM_Req_M, MEM_Ready           data-memory request and completion
//   Stall_F/D/E/M/W                hold stage registers
//   Flush_D, Flush_E               bubble IF/ID, ID/EX
//   Forward_A_E, Forward_B_E       00 regfile, 01 from W, 10 from M
//   MEM_Timeout                    sticky memory timeout
//   Stall_Cycles, Flush_Events     saturating performance counters
//
// Memory FSM states
//   state   | meaning
//   ST_IDLE | no outstanding access; a request that is not ready stalls now
//   ST_WAIT | waiting for MEM_Ready; stalls until it arrives
module hazard_control_unit #(
  parameter int RESET_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT        = 16,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [4:0]           RS1_D,
  input  logic [4:0]           RS2_D,
  input  logic [4:0]           RS1_E,
  input  logic [4:0]           RS2_E,
  input  logic [4:0]           RD_E,
  input  logic [1:0]           Result_Src_Sel_E,
  input  logic                 PC_Src_E,
  input  logic [4:0]           RD_M,
  input  logic [4:0]           RD_W,
  input  logic                 REG_W_En_M,
  input  logic                 REG_W_En_W,
  input  logic                 MEM_Req_M,
  input  logic                 MEM_Ready,
  output logic                 Stall_F,
  output logic                 Stall_D,
  output logic                 Stall_E,
  output logic                 Stall_M,
  output logic                 Stall_W,
  output logic                 Flush_D,
  output logic                 Flush_E,
  output logic [1:0]           Forward_A_E,
  output logic [1:0]           Forward_B_E,
  output logic                 MEM_Timeout,
  output logic [CNT_WIDTH-1:0] Stall_Cycles,
  output logic [CNT_WIDTH-1:0] Flush_Events
);

  localparam int RF_W = $clog2(RESET_FLUSH_CYCLES + 1);
  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {ST_IDLE, ST_WAIT} mem_state_t;

  mem_state_t      state;
  logic [RF_W-1:0] rf_cnt;
  logic [WT_W-1:0] wait_cnt;
  logic            rf_active;
  logic            load_use;
  logic            mem_stall;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [4:0] rd_w,
    input logic       we_m,
    input logic       we_w
  );
    if (we_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (we_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign Forward_A_E = fwd_sel(RS1_E, RD_M, RD_W, REG_W_En_M, REG_W_En_W);
  assign Forward_B_E = fwd_sel(RS2_E, RD_M, RD_W, REG_W_En_M, REG_W_En_W);

  assign rf_active = (rf_cnt != '0);
  assign load_use  = (Result_Src_Sel_E == 2'b01) && (RD_E != 5'd0) &&
                     ((RD_E == RS1_D) || (RD_E == RS2_D));

  // A request that is not ready stalls in the same cycle it is seen, even
  // before the FSM has moved to WAIT.
  always_comb begin
    mem_stall = 1'b0;
    if (!RST) begin
      if (state == ST_IDLE) mem_stall = MEM_Req_M && !MEM_Ready;
      else                  mem_stall = !MEM_Ready;
    end
  end

  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Stall_W = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    if (!RST) begin
      if (mem_stall) begin
        // Freeze the whole pipe; branch/load-use are re-evaluated on release.
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Stall_E = 1'b1;
        Stall_M = 1'b1;
        Stall_W = 1'b1;
      end else if (PC_Src_E) begin
        Flush_D = 1'b1;
        Flush_E = 1'b1;
      end else if (load_use) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Flush_E = 1'b1;
      end
    end
    if (rf_active) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      MEM_Timeout  <= 1'b0;
      rf_cnt       <= RF_W'(RESET_FLUSH_CYCLES);
      Stall_Cycles <= '0;
      Flush_Events <= '0;
    end else begin
      if (rf_active) rf_cnt <= rf_cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (MEM_Req_M && !MEM_Ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt != WT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
          // This edge closes WAIT cycle number wait_cnt+1.
          if (wait_cnt >= WT_W'(MEM_TIMEOUT - 1)) MEM_Timeout <= 1'b1;
          if (MEM_Ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (Stall_F && Stall_Cycles != '1) Stall_Cycles <= Stall_Cycles + 1'b1;
      // Reset-flush bubbles are housekeeping, not pipeline events.
      if (Flush_E && !rf_active && Flush_Events != '1)
        Flush_Events <= Flush_Events + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit
//   Directed test-plan steps followed by randomized traffic, all checked
//   against a behavioural model of the hazard rules kept in this file.
module tb_hazard_control_unit;

  localparam int RFC  = 2;
  localparam int TMO  = 16;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [4:0]    RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic [1:0]    Result_Src_Sel_E;
  logic          PC_Src_E, REG_W_En_M, REG_W_En_W, MEM_Req_M, MEM_Ready;
  logic          Stall_F, Stall_D, Stall_E, Stall_M, Stall_W, Flush_D, Flush_E;
  logic [1:0]    Forward_A_E, Forward_B_E;
  logic          MEM_Timeout;
  logic [CW-1:0] Stall_Cycles, Flush_Events;

  int tests = 0;
  int fails = 0;

  // model state
  int m_rf, m_wait_len, m_stall_cnt, m_flush_cnt;
  bit m_waiting, m_timeout;

  hazard_control_unit #(
    .RESET_FLUSH_CYCLES(RFC), .MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .Result_Src_Sel_E(Result_Src_Sel_E), .PC_Src_E(PC_Src_E),
    .RD_M(RD_M), .RD_W(RD_W), .REG_W_En_M(REG_W_En_M), .REG_W_En_W(REG_W_En_W),
    .MEM_Req_M(MEM_Req_M), .MEM_Ready(MEM_Ready),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Stall_W(Stall_W), .Flush_D(Flush_D), .Flush_E(Flush_E),
    .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E),
    .MEM_Timeout(MEM_Timeout), .Stall_Cycles(Stall_Cycles), .Flush_Events(Flush_Events)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (REG_W_En_M && RD_M != 0 && RD_M == rs) return 2'b10;
    if (REG_W_En_W && RD_W != 0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {Stall_F, Stall_D, Stall_E, Stall_M, Stall_W, Flush_D, Flush_E}
  function automatic logic [6:0] ref_ctl();
    bit lu, ms, fd, fe;
    logic [4:0] st;
    lu = (Result_Src_Sel_E == 2'b01) && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
    ms = m_waiting ? !MEM_Ready : (MEM_Req_M && !MEM_Ready);
    st = 5'b0; fd = 0; fe = 0;
    if (!RST) begin
      if (ms) st = 5'b11111;
      else if (PC_Src_E) begin fd = 1; fe = 1; end
      else if (lu) begin st = 5'b11000; fe = 1; end
    end
    if (m_rf > 0) begin fd = 1; fe = 1; end
    return {st, fd, fe};
  endfunction

  task automatic model_reset();
    m_rf = RFC; m_wait_len = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    m_waiting = 0; m_timeout = 0;
  endtask

  task automatic model_edge();
    logic [6:0] c;
    c = ref_ctl();
    if (c[6] && m_stall_cnt < CMAX) m_stall_cnt++;
    if (c[0] && m_rf == 0 && m_flush_cnt < CMAX) m_flush_cnt++;
    if (m_rf > 0) m_rf--;
    if (m_waiting) begin
      m_wait_len++;
      if (m_wait_len >= TMO) m_timeout = 1;
      if (MEM_Ready) begin m_waiting = 0; m_wait_len = 0; end
    end else if (MEM_Req_M && !MEM_Ready) m_waiting = 1;
  endtask

  task automatic check_all();
    chk("stall_flush", 32'({Stall_F, Stall_D, Stall_E, Stall_M, Stall_W, Flush_D, Flush_E}), 32'(ref_ctl()));
    chk("fwd_a", 32'(Forward_A_E), 32'(ref_fwd(RS1_E)));
    chk("fwd_b", 32'(Forward_B_E), 32'(ref_fwd(RS2_E)));
    chk("timeout", 32'(MEM_Timeout), 32'(m_timeout));
    chk("stall_cycles", 32'(Stall_Cycles), 32'(m_stall_cnt));
    chk("flush_events", 32'(Flush_Events), 32'(m_flush_cnt));
  endtask

  // One clock: check at negedge, advance model at posedge, return at posedge+1.
  task automatic tick();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    if (!RST) model_edge();
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    Result_Src_Sel_E = 2'b00; PC_Src_E = 0; REG_W_En_M = 0; REG_W_En_W = 0;
    MEM_Req_M = 0; MEM_Ready = 0;
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    model_reset();
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic randomize_inputs(input int ready_pct);
    RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
    RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
    RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
    RD_W  = 5'($urandom_range(0, 3));
    Result_Src_Sel_E = 2'($urandom_range(0, 3));
    PC_Src_E   = ($urandom_range(0, 3) == 0);
    REG_W_En_M = 1'($urandom_range(0, 1));
    REG_W_En_W = 1'($urandom_range(0, 1));
    MEM_Req_M  = ($urandom_range(0, 2) == 0);
    MEM_Ready  = ($urandom_range(0, 99) < ready_pct);
  endtask

  initial begin
    int f0, s0;
    idle_inputs();
    reset_dut();

    // 1: reset-flush lasts exactly RFC edges
    settle(); chk("t1_flush_edge1", 32'({Flush_D, Flush_E}), 32'b11); tick();
    settle(); chk("t1_flush_edge2", 32'({Flush_D, Flush_E}), 32'b11); tick();
    settle(); chk("t1_flush_done", 32'({Flush_D, Flush_E}), 32'b00);
    chk("t1_counters", 32'({Stall_Cycles, Flush_Events}), 32'b0); tick();

    // 2: load-use
    Result_Src_Sel_E = 2'b01; RD_E = 5; RS2_D = 5;
    settle(); chk("t2_lu", 32'({Stall_F, Stall_D, Flush_E}), 32'b111); tick();
    RD_E = 0;
    settle(); chk("t2_rd0", 32'({Stall_F, Stall_D, Flush_E}), 32'b000); tick();
    idle_inputs();

    // 3: forwarding priority
    RD_M = 7; RD_W = 7; REG_W_En_M = 1; REG_W_En_W = 1; RS1_E = 7;
    settle(); chk("t3_fwd_m", 32'(Forward_A_E), 32'b10); tick();
    REG_W_En_M = 0;
    settle(); chk("t3_fwd_w", 32'(Forward_A_E), 32'b01); tick();
    RS1_E = 0;
    settle(); chk("t3_fwd_x0", 32'(Forward_A_E), 32'b00); tick();
    idle_inputs();

    // 4: branch beats load-use
    PC_Src_E = 1; Result_Src_Sel_E = 2'b01; RD_E = 3; RS1_D = 3;
    f0 = int'(Flush_Events);
    settle(); chk("t4_branch", 32'({Flush_D, Flush_E, Stall_F}), 32'b110); tick();
    chk("t4_flush_inc", 32'(int'(Flush_Events) - f0), 32'd1);
    idle_inputs();

    // 5: memory stall defers the branch
    MEM_Req_M = 1; PC_Src_E = 1;
    s0 = int'(Stall_Cycles);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t5_stalled", 32'({Stall_F, Stall_D, Stall_E, Stall_M, Stall_W, Flush_D, Flush_E}), 32'b1111100);
      tick();
    end
    MEM_Ready = 1;
    settle(); chk("t5_release", 32'({Stall_F, Stall_W, Flush_E}), 32'b001); tick();
    chk("t5_stall_cnt", 32'(int'(Stall_Cycles) - s0), 32'd3);
    idle_inputs();

    // 6: timeout, stickiness, async reset mid-wait
    MEM_Req_M = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 16) chk("t6_not_yet", 32'(MEM_Timeout), 32'd0);
      if (i == 17) chk("t6_timeout", 32'(MEM_Timeout), 32'd1);
    end
    MEM_Ready = 1; tick();
    idle_inputs(); tick();
    chk("t6_sticky", 32'(MEM_Timeout), 32'd1);
    MEM_Req_M = 1; tick(); tick();
    settle(); chk("t6_waiting", 32'(Stall_F), 32'd1);
    RST = 1'b1; model_reset(); #1;
    chk("t6_async", 32'({Stall_F, Stall_D, Stall_E, Stall_M, Stall_W, MEM_Timeout}), 32'b0);
    check_all();
    tick();
    RST = 1'b0;
    idle_inputs();

    // randomized traffic; the middle block has rare ready to reach timeouts
    for (int b = 0; b < 3; b++) begin
      reset_dut();
      for (int i = 0; i < 120; i++) begin
        randomize_inputs(b == 1 ? 6 : 45);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Hazard/control generator for the 5-stage RV32i pipeline. It produces the stall, flush and forwarding controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, including Flush_E for the ID/EX register. It contains:
- combinational load-use, branch and forwarding logic;
- a post-reset flush sequencer;
- a data-memory wait FSM with a timeout;
- saturating stall/flush performance counters.

Parameters:
RESET_FLUSH_CYCLES, 2, cycles Flush_D/Flush_E are held after RST deasserts (>=1)
MEM_TIMEOUT, 16, consecutive wait cycles before MEM_Timeout sets
CNT_WIDTH, 32, width of the performance counters

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
RS1_D, RS2_D  in  5  source registers in Decode
RS1_E, RS2_E, RD_E  in  5  source and destination registers in Execute
Result_Src_Sel_E  in  2  result select in Execute; 2'b01 = load
PC_Src_E  in  1  taken branch or jump resolved in Execute
RD_M, RD_W  in  5  destination registers in Memory and Writeback
REG_W_En_M, REG_W_En_W  in  1  register write enables in Memory and Writeback
MEM_Req_M  in  1  load/store active in Memory
MEM_Ready  in  1  data memory completes the access this cycle
Stall_F, Stall_D, Stall_E, Stall_M, Stall_W  out  1  hold the respective stage register
Flush_D, Flush_E  out  1  insert NOP into IF/ID, ID/EX
Forward_A_E, Forward_B_E  out  2  00 register file, 01 from W, 10 from M
MEM_Timeout  out  1  sticky memory-timeout error
Stall_Cycles, Flush_Events  out  CNT_WIDTH  performance counters

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - Wait counter = 0, MEM_Timeout = 0, counters = 0.
  - Reset-flush counter loads RESET_FLUSH_CYCLES.
  - All stall outputs = 0; Flush_D = Flush_E = 1.
  - Forwarding outputs follow the combinational rule.
- Reset-flush: Flush_D and Flush_E stay 1 while the counter is nonzero. The counter decrements on each rising edge with RST=0, giving exactly RESET_FLUSH_CYCLES flush edges after release.
- Forwarding (combinational, independent of stall):
  - Forward_A_E = 10 if REG_W_En_M && RD_M!=0 && RD_M==RS1_E.
  - Else 01 if REG_W_En_W && RD_W!=0 && RD_W==RS1_E.
  - Else 00. M has priority over W. Forward_B_E is identical using RS2_E.
- Load-use: LU = (Result_Src_Sel_E==2'b01) && RD_E!=0 && (RD_E==RS1_D || RD_E==RS2_D).
- Memory FSM, states IDLE and WAIT:
  - IDLE: MEM_Req_M && !MEM_Ready gives MemStall=1 combinationally in that cycle and moves to WAIT.
  - WAIT: MemStall=1 until MEM_Ready=1. In the cycle MEM_Ready=1, MemStall=0 and the FSM returns to IDLE.
  - The wait counter increments each WAIT cycle and clears in IDLE. When it reaches MEM_TIMEOUT, MEM_Timeout sets and holds until RST. The stall continues and nothing else changes.
- Output priority:
  1. MemStall: all Stall_* = 1. Flush_D = Flush_E = 0 (reset-flush excepted). LU and PC_Src_E are deferred and re-evaluated in the cycle the stall releases. Holding W rewrites the same register, which is idempotent.
  2. PC_Src_E: Flush_D = Flush_E = 1, no stall. The branch wins over a simultaneous LU.
  3. LU: Stall_F = Stall_D = 1 and Flush_E = 1.
  4. Otherwise all stalls 0 and flushes 0.
- During reset-flush, Flush_D/Flush_E are forced to 1 regardless of priority. Stalls still follow the rules above.
- Stall_Cycles increments each edge with Stall_F=1.
- Flush_Events increments each edge with Flush_E=1 outside reset-flush.
- Both counters saturate at all-ones.
- RST mid-WAIT: FSM returns to IDLE immediately and outputs take reset values asynchronously.

Test Plan:
1. RST 1→0, all inputs idle → Flush_D = Flush_E = 1 for exactly 2 edges, then 0. Counters remain 0.
2. Result_Src_Sel_E=01, RD_E=5, RS2_D=5 → Stall_F = Stall_D = Flush_E = 1 that cycle. With RD_E=0 instead → no stall.
3. RD_M=RD_W=7 with both write enables set, RS1_E=7 → Forward_A_E = 10. Clear REG_W_En_M → 01. With RS1_E=0 → 00.
4. PC_Src_E=1 together with load-use → Flush_D = Flush_E = 1, Stall_F = 0. Flush_Events increments by 1.
5. MEM_Req_M=1, MEM_Ready=0 for 3 cycles then 1, while PC_Src_E=1 → all stalls 1 for 3 cycles with no flush. In the ready cycle, stalls drop and Flush_E = 1. Stall_Cycles = 3.
6. MEM_Ready held 0 for 20 cycles → MEM_Timeout sets after 16 WAIT cycles and stays 1 after ready. Pulsing RST mid-wait clears it and all stalls immediately.
